// File: rtl/sle_arbiter_pkg.sv
// Shared types and defaults for the round-robin signed-compare arbiter.
package sle_arbiter_pkg;

   localparam int SLE_N_DEF     = 4;
   localparam int SLE_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } sle_state_e;

   typedef logic [$clog2(SLE_N_DEF)-1:0] sle_idx_t;

endpackage

// File: rtl/sle_core.sv
// Combinational A <= B comparator: invert A, add to B with carry-in 1, fix up on sign mismatch.
// With SLE_ARBITER_UNSIGNED_EN defined, UNS selects the unsigned result (carry out).
module sle_core
   import sle_arbiter_pkg::*;
#(
   parameter int WIDTH = SLE_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
`ifdef SLE_ARBITER_UNSIGNED_EN
   input  logic             UNS,
`endif
   output logic             O
);

   logic [WIDTH-1:0] inv_a;
   logic [WIDTH-1:0] diff;
   logic             signs_differ;
   logic             sle_signed;

   assign inv_a = ~I0;

`ifdef SLE_ARBITER_UNSIGNED_EN
   logic carry;
   assign {carry, diff} = {1'b0, I1} + {1'b0, inv_a} + {{WIDTH{1'b0}}, 1'b1};
`else
   assign diff = I1 + inv_a + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

   // Mixed signs can overflow the difference, so the sign of A decides directly.
   assign signs_differ = I0[WIDTH-1] ^ I1[WIDTH-1];
   assign sle_signed   = signs_differ ? I0[WIDTH-1] : ~diff[WIDTH-1];

`ifdef SLE_ARBITER_UNSIGNED_EN
   assign O = UNS ? carry : sle_signed;
`else
   assign O = sle_signed;
`endif

endmodule

// File: rtl/sle_arbiter.sv
// Round-robin arbiter sharing one sle_core among N requesters; IDLE -> CMP -> RESP per grant.
// Optional per-client unsigned compare via MODE when SLE_ARBITER_UNSIGNED_EN is defined.
module sle_arbiter
   import sle_arbiter_pkg::*;
#(
   parameter int N     = SLE_N_DEF,
   parameter int WIDTH = SLE_WIDTH_DEF
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic [N-1:0]           REQ,
   input  logic [N*WIDTH-1:0]     A,
   input  logic [N*WIDTH-1:0]     B,
`ifdef SLE_ARBITER_UNSIGNED_EN
   input  logic [N-1:0]           MODE,
`endif
   output logic [N-1:0]           ACK,
   output logic                   RES,
   output logic                   BUSY,
   output logic [$clog2(N)-1:0]   GNT_ID
);

   localparam int IDX_W = $clog2(N);
   typedef logic [IDX_W-1:0] idx_t;
   localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

   sle_state_e       state_q;
   idx_t             ptr_q;
   idx_t             gnt_q;
   idx_t             gnt_d;
   logic [N-1:0]     ack_q;
   logic             res_q;
   logic             busy_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic             core_o;
`ifdef SLE_ARBITER_UNSIGNED_EN
   logic             uns_q;
`endif

   // Rotate so PTR sits at bit 0, take the lowest set bit, then rotate the index back.
   function automatic idx_t rr_pick(input logic [N-1:0] req, input idx_t ptr);
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot;
      idx_t           off;
      logic [IDX_W:0] sum;
      dbl = {req, req} >> ptr;
      rot = dbl[N-1:0];
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = idx_t'(i);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= N_EXT) sum = sum - N_EXT;
      return sum[IDX_W-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] slice_of(input logic [N*WIDTH-1:0] bus, input idx_t idx);
      logic [WIDTH-1:0] val;
      val = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == idx_t'(i)) val = bus[i*WIDTH +: WIDTH];
      end
      return val;
   endfunction

   assign gnt_d = rr_pick(REQ, ptr_q);

   sle_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .I0  (opa_q),
      .I1  (opb_q),
`ifdef SLE_ARBITER_UNSIGNED_EN
      .UNS (uns_q),
`endif
      .O   (core_o)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         res_q   <= 1'b0;
         busy_q  <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
`ifdef SLE_ARBITER_UNSIGNED_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|REQ) begin
                  opa_q   <= slice_of(A, gnt_d);
                  opb_q   <= slice_of(B, gnt_d);
`ifdef SLE_ARBITER_UNSIGNED_EN
                  uns_q   <= MODE[gnt_d];
`endif
                  gnt_q   <= gnt_d;
                  busy_q  <= 1'b1;
                  state_q <= CMP;
               end
            end
            CMP: begin
               res_q   <= core_o;
               ack_q   <= {{(N-1){1'b0}}, 1'b1} << gnt_q;
               state_q <= RESP;
            end
            RESP: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= (gnt_q == idx_t'(N - 1)) ? '0 : gnt_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ACK    = ack_q;
   assign RES    = res_q;
   assign BUSY   = busy_q;
   assign GNT_ID = gnt_q;

endmodule

// File: tb/tb_sle_arbiter.sv
// Randomized and directed bench for sle_arbiter against a transaction-level reference model.
// Covers the MODE port when SLE_ARBITER_UNSIGNED_EN is defined.
module tb_sle_arbiter;
   import sle_arbiter_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   logic                 CLK = 1'b0;
   logic                 RESETN;
   logic [N-1:0]         REQ;
   logic [N*W-1:0]       A;
   logic [N*W-1:0]       B;
`ifdef SLE_ARBITER_UNSIGNED_EN
   logic [N-1:0]         MODE;
`endif
   logic [N-1:0]         ACK;
   logic                 RES;
   logic                 BUSY;
   logic [$clog2(N)-1:0] GNT_ID;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference: cycles left in the current grant (2 = compare pending, 1 = ack visible).
   int       m_left;
   int       m_ptr;
   sle_idx_t m_g;
   logic     m_res;
   int       ack_ids[$];
   int       ack_cycs[$];

   sle_arbiter #(.N(N), .WIDTH(W)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .REQ    (REQ),
      .A      (A),
      .B      (B),
`ifdef SLE_ARBITER_UNSIGNED_EN
      .MODE   (MODE),
`endif
      .ACK    (ACK),
      .RES    (RES),
      .BUSY   (BUSY),
      .GNT_ID (GNT_ID)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic ref_le(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
      int ia;
      int ib;
      if (uns) begin
         ia = int'(a);
         ib = int'(b);
      end else begin
         ia = int'($signed(a));
         ib = int'($signed(b));
      end
      return ia <= ib;
   endfunction

   task automatic model_reset();
      m_left = 0;
      m_ptr  = 0;
      m_g    = '0;
      m_res  = 1'b0;
   endtask

   task automatic model_edge();
      logic uns;
      if (!RESETN) begin
         model_reset();
      end else if (m_left == 0) begin
         if (REQ != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
               if (REQ[(m_ptr + k) % N]) m_g = sle_idx_t'((m_ptr + k) % N);
            end
            uns = 1'b0;
`ifdef SLE_ARBITER_UNSIGNED_EN
            uns = MODE[m_g];
`endif
            m_res  = ref_le(A[int'(m_g)*W +: W], B[int'(m_g)*W +: W], uns);
            m_left = 2;
         end
      end else if (m_left == 2) begin
         m_left = 1;
      end else begin
         m_left = 0;
         m_ptr  = (int'(m_g) + 1) % N;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_ack;
      exp_ack = (m_left == 1) ? (N'(1) << m_g) : '0;
      chk("ack", 32'(ACK), 32'(exp_ack));
      chk("busy", 32'(BUSY), 32'(m_left != 0));
      chk("gnt_id", 32'(GNT_ID), 32'(m_g));
      if (m_left == 1) chk("res", 32'(RES), 32'(m_res));
      if (ACK != '0) begin
         for (int i = 0; i < N; i++) begin
            if (ACK[i]) ack_ids.push_back(i);
         end
         ack_cycs.push_back(cyc);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic set_ops(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
      A[c*W +: W] = a;
      B[c*W +: W] = b;
   endtask

   task automatic run_one(input string tag, input int c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic mode, input logic exp_res);
      set_ops(c, a, b);
`ifdef SLE_ARBITER_UNSIGNED_EN
      MODE[c] = mode;
`else
      if (mode) $display("note: unsigned request ignored in signed build");
`endif
      REQ = N'(1) << c;
      step();
      step();
      chk({tag, "_ack"}, 32'(ACK), 32'(N'(1) << c));
      chk({tag, "_res"}, 32'(RES), 32'(exp_res));
      REQ = '0;
      step();
   endtask

   task automatic do_reset();
      RESETN = 1'b0;
      #1;
      model_reset();
      @(negedge CLK);
      RESETN = 1'b1;
   endtask

   initial begin
      RESETN = 1'b0;
      REQ    = '0;
      A      = '0;
      B      = '0;
`ifdef SLE_ARBITER_UNSIGNED_EN
      MODE   = '0;
`endif
      model_reset();
      #12;
      chk("rst_ack", 32'(ACK), 32'h0);
      chk("rst_res", 32'(RES), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_gnt", 32'(GNT_ID), 32'h0);

      // All clients contending from reset.
      REQ = '1;
      for (int c = 0; c < N; c++) set_ops(c, W'($urandom), W'($urandom));
      ack_ids.delete();
      ack_cycs.delete();
      @(negedge CLK);
      RESETN = 1'b1;
      for (int i = 0; i < 16; i++) step();
      chk("rr_count", 32'(ack_ids.size() >= 5), 32'h1);
      if (ack_ids.size() >= 5) begin
         for (int i = 0; i < 5; i++) chk("rr_order", 32'(ack_ids[i]), 32'(i % N));
         for (int i = 1; i < 5; i++) chk("rr_gap", 32'(ack_cycs[i] - ack_cycs[i-1]), 32'd3);
      end
      REQ = '0;
      for (int i = 0; i < 4; i++) step();

      // Single signed compare on client 2.
      do_reset();
      set_ops(2, 4'hD, 4'h2);
      REQ = 4'b0100;
      step();
      chk("t2_grant_ack", 32'(ACK), 32'h0);
      step();
      chk("t2_ack", 32'(ACK), 32'h4);
      chk("t2_res", 32'(RES), 32'h1);
      chk("t2_gnt", 32'(GNT_ID), 32'h2);
      REQ = '0;
      step();

      run_one("ext_7_m8", 0, 4'h7, 4'h8, 1'b0, 1'b0);
      run_one("ext_m8_7", 0, 4'h8, 4'h7, 1'b0, 1'b1);
      run_one("eq_5_5",   0, 4'h5, 4'h5, 1'b0, 1'b1);

      // Late operand change plus dropped request on client 1.
      set_ops(1, 4'h3, 4'hE);
      REQ = 4'b0010;
      step();
      B[1*W +: W] = 4'h7;
      REQ = '0;
      step();
      chk("late_ack", 32'(ACK), 32'h2);
      chk("late_res", 32'(RES), 32'h0);
      step();

`ifdef SLE_ARBITER_UNSIGNED_EN
      run_one("uns_f_1", 3, 4'hF, 4'h1, 1'b1, 1'b0);
      run_one("sgn_f_1", 3, 4'hF, 4'h1, 1'b0, 1'b1);
`endif

      // Reset asserted during CMP.
      set_ops(2, 4'h8, 4'h7);
      REQ = 4'b0100;
      step();
      chk("pre_rst_busy", 32'(BUSY), 32'h1);
      #3;
      RESETN = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ACK), 32'h0);
      chk("mid_rst_busy", 32'(BUSY), 32'h0);
      chk("mid_rst_gnt", 32'(GNT_ID), 32'h0);
      model_reset();
      REQ = '0;
      step();
      @(negedge CLK);
      RESETN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_ack", 32'(ACK), 32'h0);
      end

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) REQ = N'($urandom);
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(1) == 0) set_ops(c, W'($urandom), W'($urandom));
         end
`ifdef SLE_ARBITER_UNSIGNED_EN
         MODE = N'($urandom);
`endif
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
